trigger_io_ctrl: RTL and testbench



---
 rtl/io_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 58 +++++
 rtl/trigger_io_ctrl.sv | 96 +++++++++
 tb/tb_trigger_io_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// ============================================================================
// Module  : io_pkg
// Brief   : Shared types and default constants for the trigger/a0 board I/O.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package io_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int DATA_WIDTH_DEF      = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIRE     = 2'd1,
        WAIT_REL = 2'd2
    } trig_state_t;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module  : btn_debounce
// Brief   : Two-flop synchronizer plus stable-run debouncer for a push button.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 != r_level) begin
                // Flip only after the synchronized input has differed for the full window
                if (r_cnt == c_cnt_last) begin
                    r_level <= ~r_level;
                    r_rise  <= ~r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

`default_nettype wire

// File: rtl/trigger_io_ctrl.sv
// ============================================================================
// Module  : trigger_io_ctrl
// Brief   : Debounced button -> core trigger, and a0 -> display publisher.
//           Optional press counter enabled by TRIGGER_IO_PRESS_COUNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module trigger_io_ctrl
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_in,
    input  logic                  trig_clr,
    output logic                  trigger,
    input  logic [DATA_WIDTH-1:0] a0,
    output logic                  disp_valid,
    output logic [DATA_WIDTH-1:0] disp_data,
`ifdef TRIGGER_IO_PRESS_COUNT_EN
    output logic [15:0]           press_count,
`endif
    input  logic                  disp_ready
);

    logic                  w_level;
    logic                  w_rise;
    trig_state_t           r_state;
    trig_state_t           w_state_next;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_last;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_in),
        .level  (w_level),
        .rise   (w_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (w_rise) w_state_next = FIRE;
            // Skip WAIT_REL when the button was already released during FIRE
            FIRE:     if (trig_clr) w_state_next = w_level ? WAIT_REL : IDLE;
            WAIT_REL: if (!w_level) w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    assign trigger = (r_state == FIRE);

`ifdef TRIGGER_IO_PRESS_COUNT_EN
    logic [15:0] r_press_count;

    always_ff @(posedge clk) begin
        if (rst)                             r_press_count <= '0;
        else if (r_state == IDLE && w_rise)  r_press_count <= r_press_count + 16'd1;
    end

    assign press_count = r_press_count;
`endif

    // Pending values are never queued: after the handshake the live a0 is compared again
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= '0;
        end else if (r_valid) begin
            if (disp_ready) r_valid <= 1'b0;
        end else if (a0 != r_last) begin
            r_data  <= a0;
            r_last  <= a0;
            r_valid <= 1'b1;
        end
    end

    assign disp_valid = r_valid;
    assign disp_data  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_trigger_io_ctrl.sv
// ============================================================================
// Module  : tb_trigger_io_ctrl
// Brief   : Directed + randomized self-checking bench for trigger_io_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trigger_io_ctrl;

    localparam int D  = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_in;
    logic          trig_clr;
    logic          trigger;
    logic [DW-1:0] a0;
    logic          disp_valid;
    logic [DW-1:0] disp_data;
    logic          disp_ready;
`ifdef TRIGGER_IO_PRESS_COUNT_EN
    logic [15:0]   press_count;
`endif

    trigger_io_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .DATA_WIDTH     (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .trig_clr   (trig_clr),
        .trigger    (trigger),
        .a0         (a0),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
`ifdef TRIGGER_IO_PRESS_COUNT_EN
        .press_count(press_count),
`endif
        .disp_ready (disp_ready)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference model: button history, run length of disagreement, and flags
    logic    bh[$];
    int      m_run;
    logic    m_level, m_rise, m_trig, m_wait;
    logic          m_valid;
    logic [DW-1:0] m_data, m_last;
    logic [15:0]   m_cnt;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        bh.delete();
        m_run = 0; m_level = 0; m_rise = 0; m_trig = 0; m_wait = 0;
        m_valid = 0; m_data = '0; m_last = '0; m_cnt = '0;
    endtask

    // One clock: advance the model from pre-edge inputs, then compare after the edge
    task automatic tick();
        logic bs;
        if (rst) begin
            model_reset();
        end else begin
            bs = (bh.size() >= 2) ? bh[bh.size()-2] : 1'b0;
            if (m_trig) begin
                if (trig_clr) begin
                    m_trig = 0;
                    m_wait = m_level;
                end
            end else if (m_wait) begin
                if (!m_level) m_wait = 0;
            end else if (m_rise) begin
                m_trig = 1;
                m_cnt  = m_cnt + 16'd1;
            end
            m_rise = 0;
            if (bs != m_level) begin
                m_run++;
                if (m_run == D) begin
                    m_level = ~m_level;
                    m_rise  = m_level;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
            if (m_valid) begin
                if (disp_ready) m_valid = 0;
            end else if (a0 != m_last) begin
                m_data  = a0;
                m_last  = a0;
                m_valid = 1;
            end
            bh.push_back(btn_in);
            if (bh.size() > 4) void'(bh.pop_front());
        end
        @(posedge clk);
        #1;
        chk("trigger", DW'(trigger), DW'(m_trig));
        chk("disp_valid", DW'(disp_valid), DW'(m_valid));
        chk("disp_data", disp_data, m_data);
`ifdef TRIGGER_IO_PRESS_COUNT_EN
        chk("press_count", DW'(press_count), DW'(m_cnt));
`endif
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Press until trigger rises; returns cycles taken, or -1 on timeout
    task automatic press_latency(output int lat);
        lat = -1;
        btn_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (trigger === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int hold;
        logic saw;

        rst = 1'b1; btn_in = 1'b0; trig_clr = 1'b0; a0 = '0; disp_ready = 1'b0;
        model_reset();
        ticks(3);
        chk("reset_trigger", DW'(trigger), '0);
        chk("reset_valid", DW'(disp_valid), '0);
        chk("reset_data", disp_data, '0);
        rst = 1'b0;
        ticks(20);

        // Bounce shorter than the debounce window must never trigger
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            btn_in = (i % 2 == 0);
            tick();
            saw |= trigger;
        end
        btn_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            saw |= trigger;
        end
        chk("bounce_no_trigger", DW'(saw), '0);

        press_latency(lat);
        chk("press_latency", DW'(lat), DW'(2 + D + 1));
        ticks(8);
        chk("trigger_held", DW'(trigger), DW'(1));
        trig_clr = 1'b1;
        tick();
        trig_clr = 1'b0;
        chk("trigger_cleared", DW'(trigger), '0);

        // Short glitch while still held: no second trigger before release
        btn_in = 1'b0; ticks(2);
        btn_in = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            saw |= trigger;
        end
        chk("no_retrigger_held", DW'(saw), '0);
        btn_in = 1'b0; ticks(10);
        press_latency(lat);
        chk("fresh_press_latency", DW'(lat), DW'(2 + D + 1));
        trig_clr = 1'b1; tick(); trig_clr = 1'b0;
        btn_in = 1'b0; ticks(10);

        // Publish handshake and drop of intermediate values
        a0 = 32'h5; disp_ready = 1'b0;
        tick();
        chk("pub_valid", DW'(disp_valid), DW'(1));
        chk("pub_data", disp_data, 32'h5);
        ticks(10);
        chk("pub_hold_data", disp_data, 32'h5);
        a0 = 32'h6; tick();
        a0 = 32'h7; tick();
        chk("pub_stable", disp_data, 32'h5);
        disp_ready = 1'b1; tick();
        disp_ready = 1'b0;
        chk("pub_accepted", DW'(disp_valid), '0);
        tick();
        chk("pub_latest_valid", DW'(disp_valid), DW'(1));
        chk("pub_latest_data", disp_data, 32'h7);

        // Mid-operation reset discards trigger and pending publish
        press_latency(lat);
        chk("pre_rst_trigger", DW'(trigger), DW'(1));
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_trigger", DW'(trigger), '0);
        chk("rst_valid", DW'(disp_valid), '0);
        chk("rst_data", disp_data, '0);
        tick();
        chk("republish_valid", DW'(disp_valid), DW'(1));
        chk("republish_data", disp_data, 32'h7);
        btn_in = 1'b0; ticks(12);

        // Randomized traffic checked against the model every cycle
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                btn_in = 1'($urandom_range(0, 1));
                hold   = int'($urandom_range(1, 12));
            end
            hold--;
            trig_clr   = ($urandom_range(0, 7) == 0);
            disp_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) a0 = DW'($urandom_range(0, 3));
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
